// File: rtl/spi_reply_tx.sv
// spi_reply_tx: SPI target-side reply transmitter.
// Shifts a status byte plus three data bytes out on spi_tx (MSB first)
// while the host clocks a frame; FILL follows once the reply is exhausted.
// Optional macro SPI_REPLY_TX_CHECKSUM_EN appends an XOR checksum byte
// (status ^ data bytes) as byte 4, making the reply five bytes long.
// reset is the host's cs_n: high deselects, tri-states spi_tx and aborts.
module spi_reply_tx #(
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic        spi_sclk,
  input  logic        reset,
  inout  wire         spi_tx,
  input  logic [7:0]  status,
  input  logic [23:0] data,
  output logic        byte_done,
  output logic [2:0]  byte_index,
  output logic        frame_done
);

`ifdef SPI_REPLY_TX_CHECKSUM_EN
  localparam int unsigned NBYTES = 5;
`else
  localparam int unsigned NBYTES = 4;
`endif
  localparam logic [2:0] LAST = 3'(NBYTES);

  logic [2:0]  bit_count;
  logic [7:0]  shift;
  logic [23:0] hold;
  logic [7:0]  load_byte;
  logic        load;

`ifdef SPI_REPLY_TX_CHECKSUM_EN
  logic [7:0]  acc;
`endif

  assign load = (bit_count == 3'd0);

  // MISO is only driven while selected
  assign spi_tx = reset ? 1'bz : shift[7];

  // Byte presented at the start of each byte slot
  always_comb begin
    load_byte = FILL;
    if (byte_index == 3'd0)      load_byte = status;
    else if (byte_index == 3'd1) load_byte = hold[23:16];
    else if (byte_index == 3'd2) load_byte = hold[15:8];
    else if (byte_index == 3'd3) load_byte = hold[7:0];
`ifdef SPI_REPLY_TX_CHECKSUM_EN
    else if (byte_index == 3'd4) load_byte = acc;
`endif
  end

  // Snapshot of the data bytes, taken with the status byte load
  always_ff @(posedge spi_sclk) begin
    if (load && byte_index == 3'd0) hold <= data;
  end

`ifdef SPI_REPLY_TX_CHECKSUM_EN
  // Running XOR of the bytes sent so far; complete by the byte-4 load
  always_ff @(posedge spi_sclk) begin
    if (load) begin
      if (byte_index == 3'd0)      acc <= status;
      else if (byte_index <= 3'd3) acc <= acc ^ load_byte;
    end
  end
`endif

  // Bit/byte counters, shifter and frame status
  always_ff @(posedge spi_sclk or posedge reset) begin
    if (reset) begin
      bit_count  <= 3'd0;
      byte_index <= 3'd0;
      shift      <= 8'hFF;
      byte_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bit_count <= bit_count + 3'd1;
      byte_done <= (bit_count == 3'd7);
      if (load) shift <= load_byte;
      else      shift <= {shift[6:0], 1'b1};
      if (bit_count == 3'd7) begin
        if (byte_index != LAST) byte_index <= byte_index + 3'd1;
        if ((4'(byte_index) + 4'd1) >= 4'(NBYTES)) frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_reply_tx.sv
// Self-checking bench for spi_reply_tx: host-side byte capture on falling
// sclk edges checked against a queue of expected reply bytes, plus per-edge
// checks of byte_done / byte_index / frame_done.
module tb_spi_reply_tx;

`ifdef SPI_REPLY_TX_CHECKSUM_EN
  localparam int NB = 5;
  localparam bit CK = 1'b1;
`else
  localparam int NB = 4;
  localparam bit CK = 1'b0;
`endif

  logic        spi_sclk;
  logic        reset;
  wire         spi_tx;
  logic [7:0]  status;
  logic [23:0] data;
  logic        byte_done;
  logic [2:0]  byte_index;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  spi_reply_tx dut (
    .spi_sclk   (spi_sclk),
    .reset      (reset),
    .spi_tx     (spi_tx),
    .status     (status),
    .data       (data),
    .byte_done  (byte_done),
    .byte_index (byte_index),
    .frame_done (frame_done)
  );

  initial spi_sclk = 1'b0;
  always #5 spi_sclk = ~spi_sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected reply: status, data bytes MSB first, optional checksum, then FILL
  task automatic push_frame(input logic [7:0] st, input logic [23:0] d, input int nbytes);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      case (i)
        0: b = st;
        1: b = d[23:16];
        2: b = d[15:8];
        3: b = d[7:0];
        4: b = CK ? (st ^ d[23:16] ^ d[15:8] ^ d[7:0]) : 8'hFF;
        default: b = 8'hFF;
      endcase
      exp_q.push_back(b);
    end
  endtask

  task automatic check_deselected(input string tag);
    check({tag, "_tx_z"}, 32'(spi_tx), 32'(1'bz));
    check({tag, "_byte_done"}, 32'(byte_done), 32'd0);
    check({tag, "_byte_index"}, 32'(byte_index), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  // Release reset on a falling edge and check the idle-high line
  task automatic start_frame(input logic [7:0] st, input logic [23:0] d);
    @(negedge spi_sclk);
    status = st;
    data   = d;
    reset  = 1'b0;
    #1;
    check("tx_idle_high", 32'(spi_tx), 32'd1);
  endtask

  // Clock `edges` rising edges, capture bits on falling edges
  task automatic run_frame(input int edges, input int chg_at, input logic [23:0] chg_data);
    logic [7:0] rx;
    int exp_idx;
    rx = 8'h00;
    for (int e = 1; e <= edges; e++) begin
      @(posedge spi_sclk);
      #1;
      exp_idx = (e / 8 < NB) ? e / 8 : NB;
      check("byte_done", 32'(byte_done), 32'((e % 8) == 0));
      check("byte_index", 32'(byte_index), 32'(exp_idx));
      check("frame_done", 32'(frame_done), 32'(e >= NB * 8));
      if (e == chg_at) data = chg_data;
      @(negedge spi_sclk);
      rx = {rx[6:0], spi_tx};
      if ((e % 8) == 0) begin
        if (exp_q.size() == 0) check("scoreboard_underrun", 32'd1, 32'd0);
        else check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic deselect();
    @(negedge spi_sclk);
    reset = 1'b1;
    #1;
    check_deselected("desel");
    repeat (2) @(negedge spi_sclk);
  endtask

  initial begin
    reset  = 1'b1;
    status = 8'h00;
    data   = 24'h0;
    repeat (3) @(negedge spi_sclk);
    #1;
    check_deselected("por");

    // Basic reply, continued clocking into FILL (7 bytes)
    push_frame(8'h81, 24'h123456, 7);
    start_frame(8'h81, 24'h123456);
    run_frame(56, 0, 24'h0);
    deselect();

    // Data changes after the snapshot are not seen
    push_frame(8'h00, 24'hAAAAAA, NB);
    start_frame(8'h00, 24'hAAAAAA);
    run_frame(NB * 8, 3, 24'h555555);
    deselect();

    // Abort mid-frame after 13 edges: only byte 0 completes
    push_frame(8'h3C, 24'h0F0F0F, 1);
    start_frame(8'h3C, 24'h0F0F0F);
    run_frame(13, 0, 24'h0);
    reset = 1'b1;
    #1;
    check_deselected("abort");
    repeat (2) @(negedge spi_sclk);

    // Fresh frame after abort restarts at byte 0
    push_frame(8'h7E, 24'h010203, NB);
    start_frame(8'h7E, 24'h010203);
    run_frame(NB * 8, 0, 24'h0);
    deselect();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
